// File: rtl/booth_dot_accumulator.sv
// Signed dot-product accumulator fed by a Booth multiplier's level-style done.
// Optional macro BOOTH_ACC_SAT_EN: saturate on signed overflow instead of wrapping.
module booth_dot_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             prod_valid,
  input  logic [15:0]      prod,
  input  logic [CNT_W-1:0] len,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam logic [ACC_W-1:0] MAXV =
    {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MINV =
    {1'b1, {(ACC_W-1){1'b0}}};

  state_t           state_q;
  logic             pv_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] rem_q;
  logic             ovf_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             accept;
  logic             start;
  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] len_m1;

  assign accept = prod_valid & ~pv_q;
  assign ext    = ACC_W'($signed(prod));
  assign sum    = acc_q + ext;
  assign add_ovf = (acc_q[ACC_W-1] == ext[ACC_W-1]) &&
                   (sum[ACC_W-1] != acc_q[ACC_W-1]);
  assign len_m1 = (len == '0) ? '0 : len - CNT_W'(1);

  // A run starts from IDLE, or from HOLD when the result leaves this cycle.
  assign start = accept &&
                 ((state_q == IDLE) ||
                  ((state_q == HOLD) && out_ready));

  // Next accumulator value: wrap or clamp on signed overflow.
  always_comb begin
    acc_d = sum;
`ifdef BOOTH_ACC_SAT_EN
    if (add_ovf) begin
      acc_d = acc_q[ACC_W-1] ? MINV : MAXV;
    end
`else
    if (add_ovf) begin
      acc_d = sum;
    end
`endif
  end

  // Edge detector on done; keeps tracking even during clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv_q <= 1'b0;
    end else begin
      pv_q <= prod_valid;
    end
  end

  // Run control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (start) begin
      acc_q  <= ext;
      rem_q  <= len_m1;
      ovf_q  <= 1'b0;
      busy_q <= 1'b1;
      if (len_m1 == '0) begin
        state_q     <= HOLD;
        out_valid_q <= 1'b1;
      end else begin
        state_q     <= ACCUM;
        out_valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | add_ovf;
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign acc_out   = out_valid_q ? acc_q : '0;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_booth_dot_accumulator.sv
// Directed bench for booth_dot_accumulator.
// Runs a 24-bit and a 16-bit instance side by side.
module tb_booth_dot_accumulator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        prod_valid;
  logic [15:0] prod;
  logic [7:0]  len;
  logic        clear;
  logic        out_ready;

  logic [23:0] acc_a;
  logic        ov_a, bz_a, of_a;
  logic [15:0] acc_b;
  logic        ov_b, bz_b, of_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  booth_dot_accumulator #(.ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .prod_valid(prod_valid),
    .prod(prod), .len(len), .clear(clear),
    .acc_out(acc_a), .out_valid(ov_a),
    .out_ready(out_ready), .busy(bz_a), .ovf(of_a)
  );

  booth_dot_accumulator #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rstn(rstn), .prod_valid(prod_valid),
    .prod(prod), .len(len), .clear(clear),
    .acc_out(acc_b), .out_valid(ov_b),
    .out_ready(out_ready), .busy(bz_b), .ovf(of_b)
  );

  task automatic pulse(input logic [15:0] p);
    @(negedge clk);
    prod = p;
    prod_valid = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({ov_a, bz_a, of_a, acc_a} !== 27'd0) begin
      fails++;
      $display("FAIL reset_a got %h want 0", {ov_a, bz_a, of_a, acc_a});
    end
    tests++;
    if ({ov_b, bz_b, of_b, acc_b} !== 19'd0) begin
      fails++;
      $display("FAIL reset_b got %h want 0", {ov_b, bz_b, of_b, acc_b});
    end
  endtask

  task automatic test_dot();
    len = 8'd3;
    pulse(16'd100);
    tests++;
    if ({bz_a, ov_a} !== 2'b10) begin
      fails++;
      $display("FAIL dot_first busy/valid got %b want 10", {bz_a, ov_a});
    end
    pulse(16'hFFCE);
    tests++;
    if (ov_a !== 1'b0) begin
      fails++;
      $display("FAIL dot_second valid got %b want 0", ov_a);
    end
    pulse(16'd7);
    tests++;
    if ({ov_a, of_a, acc_a} !== {2'b10, 24'h000039}) begin
      fails++;
      $display("FAIL dot_result got v%b o%b %h want v1 o0 000039", ov_a, of_a, acc_a);
    end
    tests++;
    if (acc_b !== 16'h0039) begin
      fails++;
      $display("FAIL dot_result16 got %h want 0039", acc_b);
    end
    @(negedge clk);
    tests++;
    if ({ov_a, acc_a} !== {1'b1, 24'h000039}) begin
      fails++;
      $display("FAIL dot_stable got v%b %h want v1 000039", ov_a, acc_a);
    end
    handshake();
    tests++;
    if ({ov_a, bz_a} !== 2'b00) begin
      fails++;
      $display("FAIL dot_drain got %b want 00", {ov_a, bz_a});
    end
  endtask

  task automatic test_held();
    len = 8'd2;
    @(negedge clk);
    prod = 16'd5;
    prod_valid = 1'b1;
    repeat (10) @(negedge clk);
    prod_valid = 1'b0;
    tests++;
    if ({bz_a, ov_a} !== 2'b10) begin
      fails++;
      $display("FAIL held_one got busy/valid %b want 10", {bz_a, ov_a});
    end
    @(negedge clk);
    pulse(16'd5);
    tests++;
    if ({ov_a, acc_a} !== {1'b1, 24'd10}) begin
      fails++;
      $display("FAIL held_result got v%b %0d want v1 10", ov_a, acc_a);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    len = 8'd1;
    out_ready = 1'b0;
    pulse(16'd3);
    tests++;
    if ({ov_a, acc_a} !== {1'b1, 24'd3}) begin
      fails++;
      $display("FAIL bp_first got v%b %0d want v1 3", ov_a, acc_a);
    end
    pulse(16'd9);
    tests++;
    if ({ov_a, acc_a} !== {1'b1, 24'd3}) begin
      fails++;
      $display("FAIL bp_drop got v%b %0d want v1 3", ov_a, acc_a);
    end
    @(negedge clk);
    prod = 16'd4;
    prod_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    out_ready = 1'b0;
    tests++;
    if ({ov_a, acc_a} !== {1'b1, 24'd4}) begin
      fails++;
      $display("FAIL bp_overlap got v%b %0d want v1 4", ov_a, acc_a);
    end
    handshake();
    tests++;
    if ({ov_a, bz_a} !== 2'b00) begin
      fails++;
      $display("FAIL bp_drain got %b want 00", {ov_a, bz_a});
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp16;
    exp16 = 16'h8000;
`ifdef BOOTH_ACC_SAT_EN
    exp16 = 16'h7FFF;
`endif
    len = 8'd2;
    pulse(16'h7FFF);
    pulse(16'h0001);
    tests++;
    if ({ov_b, of_b, acc_b} !== {2'b11, exp16}) begin
      fails++;
      $display("FAIL ovf16 got v%b o%b %h want v1 o1 %h", ov_b, of_b, acc_b, exp16);
    end
    tests++;
    if ({ov_a, of_a, acc_a} !== {2'b10, 24'h008000}) begin
      fails++;
      $display("FAIL ovf24 got v%b o%b %h want v1 o0 008000", ov_a, of_a, acc_a);
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tests++;
    if ({ov_b, bz_b, of_b, acc_b} !== 19'd0) begin
      fails++;
      $display("FAIL ovf_clear got %h want 0", {ov_b, bz_b, of_b, acc_b});
    end
  endtask

  task automatic test_clear();
    len = 8'd3;
    pulse(16'd10);
    tests++;
    if (bz_a !== 1'b1) begin
      fails++;
      $display("FAIL clr_busy got %b want 1", bz_a);
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    tests++;
    if ({bz_a, ov_a, acc_a} !== 26'd0) begin
      fails++;
      $display("FAIL clr_abort got %h want 0", {bz_a, ov_a, acc_a});
    end
    @(negedge clk);
    clear = 1'b1;
    prod = 16'd11;
    prod_valid = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (2) @(negedge clk);
    prod_valid = 1'b0;
    tests++;
    if (bz_a !== 1'b0) begin
      fails++;
      $display("FAIL clr_edge_discard got busy %b want 0", bz_a);
    end
  endtask

  task automatic test_len0();
    len = 8'd0;
    pulse(16'hFFFF);
    tests++;
    if ({ov_a, acc_a} !== {1'b1, 24'hFFFFFF}) begin
      fails++;
      $display("FAIL len0 got v%b %h want v1 ffffff", ov_a, acc_a);
    end
    tests++;
    if (acc_b !== 16'hFFFF) begin
      fails++;
      $display("FAIL len0_16 got %h want ffff", acc_b);
    end
    handshake();
  endtask

  task automatic test_async_reset();
    len = 8'd3;
    pulse(16'd20);
    pulse(16'd30);
    #2;
    rstn = 1'b0;
    #1;
    tests++;
    if ({ov_a, bz_a, of_a, acc_a} !== 27'd0) begin
      fails++;
      $display("FAIL arst got %h want 0", {ov_a, bz_a, of_a, acc_a});
    end
    len = 8'd1;
    prod = 16'd6;
    prod_valid = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    tests++;
    if ({ov_a, acc_a} !== {1'b1, 24'd6}) begin
      fails++;
      $display("FAIL rst_high_done got v%b %0d want v1 6", ov_a, acc_a);
    end
    handshake();
    repeat (3) @(negedge clk);
    tests++;
    if ({bz_a, ov_a} !== 2'b00) begin
      fails++;
      $display("FAIL rst_no_reaccept got %b want 00", {bz_a, ov_a});
    end
    prod_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    prod_valid = 1'b0;
    prod = '0;
    len = 8'd1;
    clear = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rstn = 1'b1;
    @(negedge clk);
    test_dot();
    test_held();
    test_back_to_back();
    test_overflow();
    test_clear();
    test_len0();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
